fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch initiator for the pipelined core. It owns the program counter and drives the word address into the combinational instruction memory. It captures each returned instruction with its PC in a small in-order queue and hands entries to decode over a valid/ready handshake. Branch and jump redirects from execute flush the queue and restart fetch at the target.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `DEPTH`, 2, fetch-queue entries; power of two, at least 2.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `imem_addr`  output  32  byte address to instruction memory; equals the PC register.
- `imem_inst`  input  32  instruction word; valid in the same cycle as `imem_addr` (combinational memory).
- `redirect_valid`  input  1  execute requests a PC change this cycle.
- `redirect_pc`  input  32  target byte address.
- `id_valid`  output  1  queue head presented to decode.
- `id_pc`  output  32  PC of the head entry.
- `id_inst`  output  32  instruction of the head entry.
- `id_ready`  input  1  decode accepts the head this cycle.
- `fault`  output  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- State:
  - `pc` (32 bits).
  - Circular queue of DEPTH {pc, inst} entries, with read/write pointers of $clog2(DEPTH) bits and `count` of $clog2(DEPTH)+1 bits.
  - `fault` bit.
- Pop: `pop = id_valid & id_ready`.
- Push:
  - `push = !redirect_valid & !fault & (count < DEPTH | pop)`.
  - A push is allowed when the queue is full only if a pop happens in the same cycle.
  - A push writes {pc, imem_inst} at the write pointer and sets `pc <= pc + 4`.
  - The PC add is a 32-bit unsigned add that wraps from 0xFFFF_FFFC to 0.
- Head output:
  - `id_valid = (count != 0) & !redirect_valid`.
  - `id_pc` and `id_inst` are the head entry. Their values are don't-care when `id_valid` is 0.
- Redirect has the highest priority:
  - `count <= 0`; both pointers reset to 0.
  - `pc <= redirect_pc`.
  - No push; the pop is suppressed.
- Count update:
  - push and no pop: +1.
  - pop and no push: -1.
  - both: unchanged.
  - The pointers advance modulo DEPTH.
- Reset:
  - `pc = RESET_PC`, `count = 0`, pointers 0, `fault = 0`.
  - After reset: `id_valid = 0` and `imem_addr = RESET_PC`.
  - Reset during any operation discards all queue contents and any redirect in that cycle.
- Entries leave the queue in program order. No entry is duplicated or dropped except by a flush.

## Timing
- `imem_addr` is combinational from `pc`. The instruction is sampled at the end of the same cycle.
- Fetch-to-decode latency is 1 cycle: a word fetched in cycle t is presented on `id_*` in cycle t+1 at the earliest.
- Redirect asserted in cycle N:
  - cycle N+1: `imem_addr = redirect_pc`.
  - cycle N+2: the first target instruction is valid on `id_*`.
  - The entry presented in cycle N is never accepted.
- Steady state with `id_ready` held high: one instruction per cycle, with queue occupancy 1.
- With `id_ready` held low: the queue fills in DEPTH cycles, then `pc` holds and `id_*` stays stable.
- `redirect_valid` is sampled every cycle, with or without a stall.

## Configuration
- Macro: `FETCH_MISALIGN_CHECK_EN`.
- Defined:
  - A redirect with `redirect_pc[1:0] != 0` performs the flush and loads `pc`, and also sets `fault <= 1`.
  - While `fault` is 1, push is blocked, so `id_valid` stays 0 after the flush. `imem_addr` holds the faulting target.
  - `fault` clears only on `rst`. A later redirect does not clear it.
- Not defined:
  - `fault` is tied to 0.
  - Redirect targets are loaded unchecked, and bits [1:0] pass through to `imem_addr`. The memory ignores them via word indexing.

## Test plan
- Reset with `RESET_PC`=0x0: hold `rst` 3 cycles, then release with `id_ready`=1 → `id_valid`=0 during reset; `imem_addr` sequence is 0x0, 0x4, 0x8; the `id_pc` sequence 0x0, 0x4, 0x8 starts one cycle after release, with `id_inst` matching the memory image.
- Backpressure with DEPTH=2: drop `id_ready` after the first accept → within 2 cycles `count`=2 and `pc` freezes. `id_pc` holds its value. On re-assert, the entries drain in order with no gap or duplicate.
- Full queue with simultaneous pop: `id_ready`=1 while `count`=2 → a push and a pop occur in the same cycle; `count` stays 2 and `pc` advances by 4.
- Redirect on full queue: assert `redirect_valid` with `redirect_pc`=0x40 while stalled → `id_valid`=0 that cycle. Next cycle `imem_addr`=0x40; the cycle after, `id_pc`=0x40. Neither stale entry ever appears.
- Redirect and reset in the same cycle: assert both → reset wins; `pc`=`RESET_PC` and the queue is empty.
- Misaligned redirect with `FETCH_MISALIGN_CHECK_EN`: `redirect_pc`=0x42 → `fault`=1 next cycle, and `id_valid` stays 0 for 10 or more cycles despite further aligned redirects. Without the macro, `fault` stays 0 and `imem_addr`=0x42, then 0x46.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch initiator with in-order fetch queue
//
// Owns the program counter and drives it as the byte address of a
// combinational instruction memory. Each returned word is captured together
// with its PC in a circular queue of DEPTH entries. The queue head is offered
// to decode over a valid/ready handshake. A redirect from execute flushes the
// queue and restarts fetch at the target.
//
// Ports:
//   clk            single clock, rising edge
//   rst            synchronous active-high reset
//   imem_addr      byte address to instruction memory (the PC register)
//   imem_inst      instruction word for imem_addr, same cycle
//   redirect_valid execute requests a PC change this cycle
//   redirect_pc    redirect target byte address
//   id_valid       queue head presented to decode
//   id_pc          PC of the head entry
//   id_inst        instruction of the head entry
//   id_ready       decode accepts the head this cycle
//   fault          sticky misaligned-redirect flag
//
// Optional feature: define FETCH_MISALIGN_CHECK_EN to make a redirect whose
// target is not word aligned set the sticky fault flag, which blocks further
// fetch until reset. Without it, fault is tied to 0.

module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_inst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   input  logic        id_ready,
   output logic        fault
);

   localparam int             PW   = $clog2(DEPTH);
   localparam int             CW   = PW + 1;
   localparam logic [CW-1:0]  FULL = CW'(DEPTH);

   logic [31:0]   pc;
   logic [31:0]   q_pc   [DEPTH];
   logic [31:0]   q_inst [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;

   assign imem_addr = pc;

   // A redirect hides the head so the entry presented in that cycle is
   // never accepted; this also suppresses the pop.
   assign id_valid = (count != '0) & ~redirect_valid;
   assign id_pc    = q_pc[rd_ptr];
   assign id_inst  = q_inst[rd_ptr];

   assign pop  = id_valid & id_ready;
   // A full queue still accepts a new word when the head leaves this cycle.
   assign push = ~redirect_valid & ~fault & ((count < FULL) | pop);

`ifdef FETCH_MISALIGN_CHECK_EN
   logic fault_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         fault_q <= 1'b0;
      end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
         fault_q <= 1'b1;
      end
   end

   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         pc     <= RESET_PC;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect_valid) begin
         pc     <= redirect_pc;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            pc     <= pc + 32'd4;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage needs no reset: count gates whether anything is visible.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         q_pc[wr_ptr]   <= pc;
         q_inst[wr_ptr] <= imem_inst;
      end
   end

endmodule
